// File: rtl/mcs8_sys_ctrl.sv
// mcs8_sys_ctrl: system-side bus controller for the MCS8 core.
// Decodes the CPU state code on qualified edges (SYNC_I=1) to latch the
// address, cycle type and I/O port, drive memory/I/O strobes and READY with
// programmable wait states, and raise INT_O. On the interrupt-acknowledge
// fetch it jams an RST instruction onto the CPU data bus instead of reading
// memory.
module mcs8_sys_ctrl #(
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [2:0]  RST_VEC     = 3'd7
) (
  input  logic        CLK1_I,
  input  logic        nRST_I,
  input  logic        SYNC_I,
  input  logic [2:0]  STATE_I,
  input  logic [7:0]  D_I,
  input  logic [7:0]  MEM_DATA_I,
  input  logic [7:0]  IO_DATA_I,
  input  logic        INT_REQ_I,
  output logic        INT_O,
  output logic        READY_O,
  output logic [13:0] ADDR_O,
  output logic [1:0]  CYC_O,
  output logic [4:0]  PORT_O,
  output logic        MEM_RD_O,
  output logic        MEM_WR_O,
  output logic        IO_RD_O,
  output logic        IO_WR_O,
  output logic [7:0]  WR_DATA_O,
  output logic [7:0]  D_O,
  output logic        D_OE_O
);

  // CPU state codes as presented on STATE_I.
  typedef enum logic [2:0] {
    ST_WAIT = 3'b000,
    ST_T3   = 3'b001,
    ST_T1   = 3'b010,
    ST_STOP = 3'b011,
    ST_T2   = 3'b100,
    ST_T5   = 3'b101,
    ST_T1I  = 3'b110,
    ST_T4   = 3'b111
  } cpu_state_e;

  // Cycle type carried in D_I[7:6] at T2.
  typedef enum logic [1:0] {
    CYC_PCI = 2'b00,  // instruction fetch
    CYC_PCR = 2'b01,  // memory read
    CYC_PCC = 2'b10,  // I/O command
    CYC_PCW = 2'b11   // memory write
  } cyc_e;

  localparam logic [2:0] WAIT_INIT   = 3'(WAIT_STATES);
  localparam logic       READY_AT_T2 = (WAIT_STATES == 0);
  localparam logic [7:0] RST_INSTR   = {2'b00, RST_VEC, 3'b101};

  cpu_state_e state;
  cyc_e       t2_cyc;
  logic       t2_inp;     // port in D_I[5:1] is an input port (< 8)
  logic       out_port;   // latched port is an output port (>= 8)

  assign state    = cpu_state_e'(STATE_I);
  assign t2_cyc   = cyc_e'(D_I[7:6]);
  assign t2_inp   = (D_I[5:4] == 2'b00);
  assign out_port = (PORT_O[4:3] != 2'b00);

  // Registered state and its next-state values.
  logic [13:0] addr_q,    addr_d;
  cyc_e        cyc_q,     cyc_d;
  logic [4:0]  port_q,    port_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic [2:0]  wait_cnt_q, wait_cnt_d;
  logic        ready_q,   ready_d;
  logic        mem_rd_q,  mem_rd_d;
  logic        mem_wr_q,  mem_wr_d;
  logic        io_rd_q,   io_rd_d;
  logic        io_wr_q,   io_wr_d;
  logic        d_oe_q,    d_oe_d;
  logic        int_q,     int_d;
  logic        ack_q,     ack_d;

  // Next-state decode: everything holds unless a qualified edge says otherwise.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    addr_d     = addr_q;
    cyc_d      = cyc_q;
    port_d     = port_q;
    wr_data_d  = wr_data_q;
    wait_cnt_d = wait_cnt_q;
    ready_d    = ready_q;
    mem_rd_d   = mem_rd_q;
    mem_wr_d   = mem_wr_q;
    io_rd_d    = io_rd_q;
    io_wr_d    = io_wr_q;
    d_oe_d     = d_oe_q;
    int_d      = int_q;
    ack_d      = ack_q;

    if (SYNC_I) begin
      // Interrupt line: acknowledge clears, and wins over a new request.
      if (state == ST_T1I) begin
        int_d = 1'b0;
      end else if (INT_REQ_I && !ack_q) begin
        int_d = 1'b1;
      end

      // Write strobes last exactly one qualified-state interval.
      mem_wr_d = 1'b0;
      io_wr_d  = 1'b0;

      case (state)
        ST_T1, ST_T1I: begin
          addr_d[7:0] = D_I;
          mem_rd_d    = 1'b0;
          io_rd_d     = 1'b0;
          d_oe_d      = 1'b0;
          if (state == ST_T1I) begin
            ack_d = 1'b1;
          end
        end

        ST_T2: begin
          addr_d[13:8] = D_I[5:0];
          cyc_d        = t2_cyc;
          wait_cnt_d   = WAIT_INIT;
          ready_d      = READY_AT_T2;
          mem_rd_d     = 1'b0;
          io_rd_d      = 1'b0;
          d_oe_d       = 1'b0;
          case (t2_cyc)
            CYC_PCI: begin
              // A fetch during interrupt acknowledge is jammed: no memory read.
              mem_rd_d = !ack_q;
              d_oe_d   = 1'b1;
            end
            CYC_PCR: begin
              mem_rd_d = 1'b1;
              d_oe_d   = 1'b1;
            end
            CYC_PCC: begin
              port_d = D_I[5:1];
              if (t2_inp) begin
                io_rd_d = 1'b1;
                d_oe_d  = 1'b1;
              end
            end
            default: ;  // PCW: the write strobe waits for T3 data
          endcase
        end

        ST_WAIT: begin
          if (wait_cnt_q != 3'd0) begin
            wait_cnt_d = wait_cnt_q - 3'd1;
            if (wait_cnt_q == 3'd1) begin
              ready_d = 1'b1;
            end
          end
        end

        ST_T3: begin
          mem_rd_d = 1'b0;
          io_rd_d  = 1'b0;
          d_oe_d   = 1'b0;
          ready_d  = 1'b1;
          if (cyc_q == CYC_PCW) begin
            wr_data_d = D_I;
            mem_wr_d  = 1'b1;
          end else if (cyc_q == CYC_PCC && out_port) begin
            // OUT carries the accumulator in the low address byte.
            wr_data_d = addr_q[7:0];
            io_wr_d   = 1'b1;
          end
          if (cyc_q == CYC_PCI) begin
            ack_d = 1'b0;
          end
        end

        default: begin  // T4, T5, STOP
          mem_rd_d = 1'b0;
          io_rd_d  = 1'b0;
          d_oe_d   = 1'b0;
        end
      endcase
    end
  end

  // State register; reset drops strobes at once and discards a pending jam.
  always_ff @(posedge CLK1_I or negedge nRST_I) begin
    if (!nRST_I) begin
      addr_q     <= '0;
      cyc_q      <= CYC_PCI;
      port_q     <= '0;
      wr_data_q  <= '0;
      wait_cnt_q <= '0;
      ready_q    <= 1'b1;
      mem_rd_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      io_rd_q    <= 1'b0;
      io_wr_q    <= 1'b0;
      d_oe_q     <= 1'b0;
      int_q      <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      addr_q     <= addr_d;
      cyc_q      <= cyc_d;
      port_q     <= port_d;
      wr_data_q  <= wr_data_d;
      wait_cnt_q <= wait_cnt_d;
      ready_q    <= ready_d;
      mem_rd_q   <= mem_rd_d;
      mem_wr_q   <= mem_wr_d;
      io_rd_q    <= io_rd_d;
      io_wr_q    <= io_wr_d;
      d_oe_q     <= d_oe_d;
      int_q      <= int_d;
      ack_q      <= ack_d;
    end
  end

  // Data returned to the CPU: input port, jammed RST, or memory.
  always_comb begin
    D_O = 8'h00;
    if (d_oe_q) begin
      if (io_rd_q) begin
        D_O = IO_DATA_I;
      end else if (cyc_q == CYC_PCI && ack_q) begin
        D_O = RST_INSTR;
      end else begin
        D_O = MEM_DATA_I;
      end
    end
  end

  assign INT_O     = int_q;
  assign READY_O   = ready_q;
  assign ADDR_O    = addr_q;
  assign CYC_O     = cyc_q;
  assign PORT_O    = port_q;
  assign MEM_RD_O  = mem_rd_q;
  assign MEM_WR_O  = mem_wr_q;
  assign IO_RD_O   = io_rd_q;
  assign IO_WR_O   = io_wr_q;
  assign WR_DATA_O = wr_data_q;
  assign D_OE_O    = d_oe_q;

endmodule

// File: tb/tb_mcs8_sys_ctrl.sv
// Testbench for mcs8_sys_ctrl: two instances (0 and 2 wait states, different
// RST vectors) share stimulus. A directed table, hand sequences for wait
// states and asynchronous reset, then random cycles checked against a
// behavioural model of the bus rules.
module tb_mcs8_sys_ctrl;

  localparam logic [2:0] S_WAIT = 3'b000, S_T3 = 3'b001, S_T1 = 3'b010,
                         S_STOP = 3'b011, S_T2 = 3'b100, S_T5 = 3'b101,
                         S_T1I  = 3'b110, S_T4 = 3'b111;

  logic       CLK1_I = 1'b0;
  logic       nRST_I;
  logic       SYNC_I;
  logic [2:0] STATE_I;
  logic [7:0] D_I, MEM_DATA_I, IO_DATA_I;
  logic       INT_REQ_I;

  logic a_int, a_ready, a_mem_rd, a_mem_wr, a_io_rd, a_io_wr, a_oe;
  logic b_int, b_ready, b_mem_rd, b_mem_wr, b_io_rd, b_io_wr, b_oe;
  logic [13:0] a_addr, b_addr;
  logic [1:0]  a_cyc, b_cyc;
  logic [4:0]  a_port, b_port;
  logic [7:0]  a_wr, b_wr, a_d, b_d;

  always #5 CLK1_I = ~CLK1_I;

  mcs8_sys_ctrl #(.WAIT_STATES(0), .RST_VEC(3'd3)) u_a (
    .CLK1_I(CLK1_I), .nRST_I(nRST_I), .SYNC_I(SYNC_I), .STATE_I(STATE_I),
    .D_I(D_I), .MEM_DATA_I(MEM_DATA_I), .IO_DATA_I(IO_DATA_I),
    .INT_REQ_I(INT_REQ_I), .INT_O(a_int), .READY_O(a_ready), .ADDR_O(a_addr),
    .CYC_O(a_cyc), .PORT_O(a_port), .MEM_RD_O(a_mem_rd), .MEM_WR_O(a_mem_wr),
    .IO_RD_O(a_io_rd), .IO_WR_O(a_io_wr), .WR_DATA_O(a_wr), .D_O(a_d),
    .D_OE_O(a_oe));

  mcs8_sys_ctrl #(.WAIT_STATES(2)) u_b (
    .CLK1_I(CLK1_I), .nRST_I(nRST_I), .SYNC_I(SYNC_I), .STATE_I(STATE_I),
    .D_I(D_I), .MEM_DATA_I(MEM_DATA_I), .IO_DATA_I(IO_DATA_I),
    .INT_REQ_I(INT_REQ_I), .INT_O(b_int), .READY_O(b_ready), .ADDR_O(b_addr),
    .CYC_O(b_cyc), .PORT_O(b_port), .MEM_RD_O(b_mem_rd), .MEM_WR_O(b_mem_wr),
    .IO_RD_O(b_io_rd), .IO_WR_O(b_io_wr), .WR_DATA_O(b_wr), .D_O(b_d),
    .D_OE_O(b_oe));

  typedef struct packed {
    logic [13:0] addr;
    logic [1:0]  cyc;
    logic [4:0]  port;
    logic [7:0]  wr;
    logic [7:0]  d;
    logic mem_rd, mem_wr, io_rd, io_wr, oe, ready, intr;
  } obs_t;

  obs_t obs_a, obs_b;
  assign obs_a = {a_addr, a_cyc, a_port, a_wr, a_d, a_mem_rd, a_mem_wr,
                  a_io_rd, a_io_wr, a_oe, a_ready, a_int};
  assign obs_b = {b_addr, b_cyc, b_port, b_wr, b_d, b_mem_rd, b_mem_wr,
                  b_io_rd, b_io_wr, b_oe, b_ready, b_int};

  // Behavioural model of one controller instance.
  typedef struct {
    logic [13:0] addr;
    logic [1:0]  cyc;
    logic [4:0]  port;
    logic [7:0]  wr;
    logic mem_rd, mem_wr, io_rd, io_wr, oe, ready, intr, ack;
    int   waits_left;
  } mdl_t;

  mdl_t m_a, m_b;
  int total = 0;
  int bad   = 0;

  function automatic mdl_t mdl_reset();
    mdl_t s;
    s.addr = '0; s.cyc = '0; s.port = '0; s.wr = '0;
    s.mem_rd = 0; s.mem_wr = 0; s.io_rd = 0; s.io_wr = 0; s.oe = 0;
    s.ready = 1; s.intr = 0; s.ack = 0; s.waits_left = 0;
    return s;
  endfunction

  function automatic mdl_t mdl_edge(mdl_t s, int ws, logic sync,
                                    logic [2:0] st, logic [7:0] d, logic req);
    mdl_t n = s;
    if (!sync) return s;
    if (st == S_T1I) n.intr = 0;
    else if (req && !s.ack) n.intr = 1;
    n.mem_wr = 0;
    n.io_wr  = 0;
    case (st)
      S_T1, S_T1I: begin
        n.addr[7:0] = d;
        n.mem_rd = 0; n.io_rd = 0; n.oe = 0;
        if (st == S_T1I) n.ack = 1;
      end
      S_T2: begin
        n.addr[13:8] = d[5:0];
        n.cyc = d[7:6];
        if (n.cyc == 2) n.port = d[5:1];
        n.waits_left = ws;
        n.ready = (ws == 0);
        n.mem_rd = (n.cyc < 2) && !(n.cyc == 0 && s.ack);
        n.io_rd  = (n.cyc == 2) && (n.port < 8);
        n.oe     = (n.cyc < 2) || n.io_rd;
      end
      S_WAIT: begin
        if (n.waits_left > 0) begin
          n.waits_left--;
          if (n.waits_left == 0) n.ready = 1;
        end
      end
      S_T3: begin
        n.mem_rd = 0; n.io_rd = 0; n.oe = 0; n.ready = 1;
        if (s.cyc == 3) begin
          n.wr = d; n.mem_wr = 1;
        end else if (s.cyc == 2 && s.port >= 8) begin
          n.wr = s.addr[7:0]; n.io_wr = 1;
        end
        if (s.cyc == 0) n.ack = 0;
      end
      default: begin
        n.mem_rd = 0; n.io_rd = 0; n.oe = 0;
      end
    endcase
    return n;
  endfunction

  function automatic obs_t mdl_obs(mdl_t s, logic [2:0] vec,
                                   logic [7:0] mem, logic [7:0] io);
    obs_t o;
    o.addr = s.addr; o.cyc = s.cyc; o.port = s.port; o.wr = s.wr;
    o.mem_rd = s.mem_rd; o.mem_wr = s.mem_wr; o.io_rd = s.io_rd;
    o.io_wr = s.io_wr; o.oe = s.oe; o.ready = s.ready; o.intr = s.intr;
    if (!s.oe) o.d = 8'h00;
    else if (s.io_rd) o.d = io;
    else if (s.cyc == 0 && s.ack) o.d = {2'b00, vec, 3'b101};
    else o.d = mem;
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cmp(input string tag, input obs_t act, input obs_t exp);
    check({tag, ".addr"},   32'(act.addr),   32'(exp.addr));
    check({tag, ".cyc"},    32'(act.cyc),    32'(exp.cyc));
    check({tag, ".port"},   32'(act.port),   32'(exp.port));
    check({tag, ".wr"},     32'(act.wr),     32'(exp.wr));
    check({tag, ".d"},      32'(act.d),      32'(exp.d));
    check({tag, ".mem_rd"}, 32'(act.mem_rd), 32'(exp.mem_rd));
    check({tag, ".mem_wr"}, 32'(act.mem_wr), 32'(exp.mem_wr));
    check({tag, ".io_rd"},  32'(act.io_rd),  32'(exp.io_rd));
    check({tag, ".io_wr"},  32'(act.io_wr),  32'(exp.io_wr));
    check({tag, ".oe"},     32'(act.oe),     32'(exp.oe));
    check({tag, ".ready"},  32'(act.ready),  32'(exp.ready));
    check({tag, ".int"},    32'(act.intr),   32'(exp.intr));
  endtask

  task automatic cmp_models(input string tag);
    cmp({tag, "_a"}, obs_a, mdl_obs(m_a, 3'd3, MEM_DATA_I, IO_DATA_I));
    cmp({tag, "_b"}, obs_b, mdl_obs(m_b, 3'd7, MEM_DATA_I, IO_DATA_I));
  endtask

  // Drive one bus state at a negedge, clock it, and return at the next negedge.
  task automatic step_in(input logic sync, input logic [2:0] st,
                         input logic [7:0] d, input logic req);
    SYNC_I = sync; STATE_I = st; D_I = d; INT_REQ_I = req;
    @(posedge CLK1_I);
    m_a = mdl_edge(m_a, 0, sync, st, d, req);
    m_b = mdl_edge(m_b, 2, sync, st, d, req);
    @(negedge CLK1_I);
  endtask

  typedef struct {
    logic       sync;
    logic [2:0] st;
    logic [7:0] d;
    logic       req;
    obs_t       exp;  // expected outputs of u_a (0 wait states, RST 3)
  } vec_t;

  function automatic vec_t mk(logic sync, logic [2:0] st, logic [7:0] d,
                              logic req, logic [13:0] addr, logic [1:0] cyc,
                              logic [4:0] port, logic [7:0] wr, logic [7:0] dout,
                              logic mrd, logic mwr, logic ird, logic iwr,
                              logic oe, logic rdy, logic intr);
    vec_t v;
    v.sync = sync; v.st = st; v.d = d; v.req = req;
    v.exp = {addr, cyc, port, wr, dout, mrd, mwr, ird, iwr, oe, rdy, intr};
    return v;
  endfunction

  vec_t tbl[27];
  logic [2:0] q[$];

  initial begin
    // Fetch, then a non-qualified edge that must hold everything.
    tbl[0]  = mk(1, S_T1,   8'h34, 0, 14'h0034, 0, 5'h00, 8'h00, 8'h00, 0,0,0,0,0,1,0);
    tbl[1]  = mk(1, S_T2,   8'h12, 0, 14'h1234, 0, 5'h00, 8'h00, 8'h76, 1,0,0,0,1,1,0);
    tbl[2]  = mk(0, S_T3,   8'hFF, 0, 14'h1234, 0, 5'h00, 8'h00, 8'h76, 1,0,0,0,1,1,0);
    tbl[3]  = mk(1, S_T3,   8'h00, 0, 14'h1234, 0, 5'h00, 8'h00, 8'h00, 0,0,0,0,0,1,0);
    tbl[4]  = mk(1, S_T4,   8'h00, 0, 14'h1234, 0, 5'h00, 8'h00, 8'h00, 0,0,0,0,0,1,0);
    // Memory write.
    tbl[5]  = mk(1, S_T1,   8'h00, 0, 14'h1200, 0, 5'h00, 8'h00, 8'h00, 0,0,0,0,0,1,0);
    tbl[6]  = mk(1, S_T2,   8'hC5, 0, 14'h0500, 3, 5'h00, 8'h00, 8'h00, 0,0,0,0,0,1,0);
    tbl[7]  = mk(1, S_T3,   8'hA5, 0, 14'h0500, 3, 5'h00, 8'hA5, 8'h00, 0,1,0,0,0,1,0);
    tbl[8]  = mk(1, S_T4,   8'h00, 0, 14'h0500, 3, 5'h00, 8'hA5, 8'h00, 0,0,0,0,0,1,0);
    // OUT to port 9.
    tbl[9]  = mk(1, S_T1,   8'h5A, 0, 14'h055A, 3, 5'h00, 8'hA5, 8'h00, 0,0,0,0,0,1,0);
    tbl[10] = mk(1, S_T2,   8'h93, 0, 14'h135A, 2, 5'h09, 8'hA5, 8'h00, 0,0,0,0,0,1,0);
    tbl[11] = mk(1, S_T3,   8'h00, 0, 14'h135A, 2, 5'h09, 8'h5A, 8'h00, 0,0,0,1,0,1,0);
    tbl[12] = mk(1, S_T5,   8'h00, 0, 14'h135A, 2, 5'h09, 8'h5A, 8'h00, 0,0,0,0,0,1,0);
    // INP from port 1.
    tbl[13] = mk(1, S_T1,   8'h00, 0, 14'h1300, 2, 5'h09, 8'h5A, 8'h00, 0,0,0,0,0,1,0);
    tbl[14] = mk(1, S_T2,   8'h83, 0, 14'h0300, 2, 5'h01, 8'h5A, 8'hC3, 0,0,1,0,1,1,0);
    tbl[15] = mk(1, S_T3,   8'h00, 0, 14'h0300, 2, 5'h01, 8'h5A, 8'h00, 0,0,0,0,0,1,0);
    tbl[16] = mk(1, S_T4,   8'h00, 0, 14'h0300, 2, 5'h01, 8'h5A, 8'h00, 0,0,0,0,0,1,0);
    // Interrupt in STOP, acknowledge with request still held, re-raise.
    tbl[17] = mk(1, S_STOP, 8'h00, 1, 14'h0300, 2, 5'h01, 8'h5A, 8'h00, 0,0,0,0,0,1,1);
    tbl[18] = mk(1, S_STOP, 8'h00, 1, 14'h0300, 2, 5'h01, 8'h5A, 8'h00, 0,0,0,0,0,1,1);
    tbl[19] = mk(1, S_T1I,  8'h00, 1, 14'h0300, 2, 5'h01, 8'h5A, 8'h00, 0,0,0,0,0,1,0);
    tbl[20] = mk(1, S_T2,   8'h00, 1, 14'h0000, 0, 5'h01, 8'h5A, 8'h1D, 0,0,0,0,1,1,0);
    tbl[21] = mk(1, S_T3,   8'h00, 1, 14'h0000, 0, 5'h01, 8'h5A, 8'h00, 0,0,0,0,0,1,0);
    tbl[22] = mk(1, S_T4,   8'h00, 1, 14'h0000, 0, 5'h01, 8'h5A, 8'h00, 0,0,0,0,0,1,1);
    tbl[23] = mk(1, S_T5,   8'h00, 0, 14'h0000, 0, 5'h01, 8'h5A, 8'h00, 0,0,0,0,0,1,1);
    tbl[24] = mk(1, S_T1I,  8'h00, 0, 14'h0000, 0, 5'h01, 8'h5A, 8'h00, 0,0,0,0,0,1,0);
    tbl[25] = mk(1, S_T2,   8'h00, 0, 14'h0000, 0, 5'h01, 8'h5A, 8'h1D, 0,0,0,0,1,1,0);
    tbl[26] = mk(1, S_T3,   8'h00, 0, 14'h0000, 0, 5'h01, 8'h5A, 8'h00, 0,0,0,0,0,1,0);

    nRST_I = 0; SYNC_I = 0; STATE_I = S_STOP; D_I = 0; INT_REQ_I = 0;
    MEM_DATA_I = 8'h76; IO_DATA_I = 8'hC3;
    m_a = mdl_reset(); m_b = mdl_reset();
    repeat (2) @(negedge CLK1_I);
    nRST_I = 1;
    @(negedge CLK1_I);
    cmp("reset_a", obs_a, {14'h0, 2'b0, 5'h0, 8'h0, 8'h0, 7'b0000010});
    cmp_models("reset");

    // Directed table.
    for (int i = 0; i < 27; i++) begin
      step_in(tbl[i].sync, tbl[i].st, tbl[i].d, tbl[i].req);
      cmp($sformatf("tbl%0d", i), obs_a, tbl[i].exp);
      cmp_models($sformatf("tblm%0d", i));
    end

    // Two wait states on u_b: READY low through T2 and the first WAIT.
    step_in(1, S_T1, 8'h00, 0);
    step_in(1, S_T2, 8'hC5, 0);
    check("ws2_t2_ready", 32'(b_ready), 32'd0);
    step_in(1, S_WAIT, 8'h00, 0);
    check("ws2_w1_ready", 32'(b_ready), 32'd0);
    step_in(1, S_WAIT, 8'h00, 0);
    check("ws2_w2_ready", 32'(b_ready), 32'd1);
    check("ws2_w2_wr",    32'(b_mem_wr), 32'd0);
    step_in(1, S_T3, 8'hA5, 0);
    check("ws2_t3_wr",    32'(b_mem_wr), 32'd1);
    check("ws2_t3_data",  32'(b_wr),     32'hA5);
    check("ws2_t3_addr",  32'(b_addr),   32'h0500);
    step_in(1, S_T4, 8'h00, 0);
    check("ws2_t4_wr",    32'(b_mem_wr), 32'd0);
    cmp_models("ws2");

    // Asynchronous reset in the middle of a read's WAIT state.
    step_in(1, S_STOP, 8'h00, 1);
    check("pre_rst_int", 32'(a_int), 32'd1);
    step_in(1, S_T1, 8'h10, 0);
    step_in(1, S_T2, 8'h40, 0);
    step_in(1, S_WAIT, 8'h00, 0);
    check("pre_rst_rd",    32'(b_mem_rd), 32'd1);
    check("pre_rst_ready", 32'(b_ready),  32'd0);
    #2;
    nRST_I = 0;
    #1;
    check("rst_rd",    32'(b_mem_rd), 32'd0);
    check("rst_oe",    32'(b_oe),     32'd0);
    check("rst_ready", 32'(b_ready),  32'd1);
    check("rst_int_b", 32'(b_int),    32'd0);
    check("rst_int_a", 32'(a_int),    32'd0);
    m_a = mdl_reset(); m_b = mdl_reset();
    @(negedge CLK1_I);
    nRST_I = 1;
    @(negedge CLK1_I);
    cmp_models("post_rst");

    // Random cycles, mostly well-formed, some arbitrary state codes.
    for (int n = 0; n < 1500; n++) begin
      logic       sync;
      logic [2:0] st;
      logic       req;
      sync = ($urandom_range(0, 9) != 0);
      req  = ($urandom_range(0, 3) == 0);
      if (q.size() == 0) begin
        int r = $urandom_range(0, 9);
        if (r == 0) q.push_back(S_STOP);
        q.push_back((r < 3) ? S_T1I : S_T1);
        q.push_back(S_T2);
        repeat ($urandom_range(0, 3)) q.push_back(S_WAIT);
        q.push_back(S_T3);
        if ($urandom_range(0, 1) == 1) begin
          q.push_back(S_T4);
          q.push_back(S_T5);
        end
      end
      if ($urandom_range(0, 7) == 0) begin
        st = 3'($urandom_range(0, 7));
      end else begin
        st = q[0];
        if (sync) void'(q.pop_front());
      end
      MEM_DATA_I = 8'($urandom);
      IO_DATA_I  = 8'($urandom);
      step_in(sync, st, 8'($urandom), req);
      cmp_models($sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
